arb_egress_buffer: RTL
======================

// Module: arb_egress_buffer
// PURPOSE
//   Egress stage directly downstream of arbitrated_fifos. It drives the arbiter's reqs,
//   but only for non-empty FIFOs and only while it has free buffer space.
//   It captures each granted word together with the index of its source FIFO.
//   It presents the tagged words to the consumer on a valid/ready interface.
//   Its flow control means the arbiter never grants a word the buffer cannot hold.
// PARAMETERS
//   NUM_REQS  2                              number of arbitrated FIFOs / requesters
//   WIDTH     8                              data word width
//   DEPTH     4                              egress buffer entries; power of 2, >=2
//   IDW       (NUM_REQS>1)?$clog2(NUM_REQS):1   source-index tag width
//   CW        $clog2(DEPTH+1)                occupancy counter width
// PORTS
//   clk        in   1         single clock; all state updates on posedge
//   rst_n      in   1         reset, asynchronous assert, active-low
//   fifo_empty in   NUM_REQS  empty flags of the arbitrated FIFOs
//   req_out    out  NUM_REQS  requests to the arbiter (its reqs input)
//   gnt        in   NUM_REQS  arbiter grant / FIFO pop; one-hot or zero
//   data_in    in   WIDTH     arbiter data_out; valid in the same cycle as gnt
//   out_valid  out  1         head entry valid
//   out_ready  in   1         consumer accepts head this cycle
//   out_data   out  WIDTH     head data
//   out_src    out  IDW       head source FIFO index
//   count      out  CW        current buffer occupancy, 0..DEPTH
//   err        out  1         sticky protocol-error flag
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     - wr_ptr, rd_ptr and count go to 0; storage is cleared to 0.
//     - Outputs: out_valid=0, out_data=0, out_src=0, err=0.
//     - req_out=0 while rst_n=0.
//     - Reset mid-operation discards all buffered words and performs no pop.
//   Request gating (combinational from registered state only; no path from out_ready):
//     - req_out[i] = ~fifo_empty[i] & (count < DEPTH).
//     - A same-cycle pop does NOT free a slot for requesting.
//   Push:
//     - A push happens when |gnt and count < DEPTH.
//     - It writes {idx, data_in} at wr_ptr, where idx is the set bit of gnt.
//     - wr_ptr advances modulo DEPTH and wraps to 0 after DEPTH-1.
//   Pop:
//     - A pop happens when out_valid & out_ready.
//     - rd_ptr advances modulo DEPTH.
//   Count and outputs:
//     - Push and pop in the same cycle: count unchanged, both pointers advance.
//     - out_valid = (count != 0).
//     - out_data and out_src come from rd_ptr storage; there is no bypass.
//     - Minimum latency from gnt to out_valid is 1 cycle.
//     - out_valid stays high and head data stays stable until accepted (standard valid/ready).
//   Errors (err sets on the next edge and stays set until reset):
//     - More than one gnt bit set: capture the lowest set index; set err.
//     - |gnt while count == DEPTH: drop the word, no state change except err=1.
//     - gnt[i] while req_out[i] == 0: set err. The word is still captured if space exists.
//   out_ready while out_valid=0: ignored.
// TESTING
//   1. Reset, DEPTH=4; hold fifo_empty=2'b00 and out_ready=0; grant one word per cycle
//      (0xA1..0xA4) -> count reaches 4, req_out=2'b00 from the cycle after count hits 4.
//   2. gnt=2'b10 with data 0x5C, out_ready=1 -> next cycle out_valid=1, out_data=0x5C,
//      out_src=1. After the accept, count=0.
//   3. count=2, push and pop in the same cycle -> count stays 2; FIFO order is preserved
//      across the wr/rd pointer wrap from 3 to 0.
//   4. Full buffer, inject gnt=2'b01 -> word dropped, count=4, err=1.
//      err stays 1 after the buffer drains.
//   5. gnt=2'b11 with data 0x33 -> entry tagged out_src=0, err=1.
//   6. Buffer holds 3 words; deassert rst_n mid-cycle -> out_valid, count and err go to 0
//      immediately; after release, the next granted word appears first.

Source files
------------

// File: rtl/arb_egress_buffer.sv
// Egress buffer behind the FIFO arbiter: gates requests on space, stores granted words tagged with their source index.
// Latency: a granted word is visible on out_valid/out_data/out_src one cycle after gnt; there is no bypass path.
// Backpressure: requests drop while the buffer is full; out_ready only frees a slot for the cycle after the pop.
module arb_egress_buffer #(
    parameter int NUM_REQS = 2,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int IDW      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQS-1:0] fifo_empty,
    output logic [NUM_REQS-1:0] req_out,
    input  logic [NUM_REQS-1:0] gnt,
    input  logic [WIDTH-1:0]    data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [IDW-1:0]      out_src,
    output logic [CW-1:0]       count,
    output logic                err
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem_dat [DEPTH];
    logic [IDW-1:0]   mem_src [DEPTH];

    logic           has_space;
    logic           push;
    logic           pop;
    logic           multi_gnt;
    logic           drop;
    logic           unreq_gnt;
    logic [IDW-1:0] gnt_idx;

    // Space is judged on registered occupancy only, so a pop in flight never opens a request slot.
    assign has_space = (count < FULL_CNT);
    assign req_out   = rst_n ? (~fifo_empty & {NUM_REQS{has_space}}) : '0;
    assign push      = (|gnt) & has_space;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != '0);
    assign out_data  = mem_dat[rd_ptr];
    assign out_src   = mem_src[rd_ptr];

    assign multi_gnt = ((gnt & (gnt - NUM_REQS'(1))) != '0);
    assign drop      = (|gnt) & ~has_space;
    assign unreq_gnt = ((gnt & ~req_out) != '0);

    // Descending scan leaves the lowest set grant bit as the tag.
    always_comb begin
        gnt_idx = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (gnt[i]) gnt_idx = IDW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_dat[i] <= '0;
                mem_src[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_dat[wr_ptr] <= data_in;
                mem_src[wr_ptr] <= gnt_idx;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            err <= err | multi_gnt | drop | unreq_gnt;
        end
    end

endmodule
